// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RISC-V control FSM with combinational output decode
module multicycle_ctrl #(
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               op,
  input  logic [2:0]               funct3,
  input  logic                     funct7b5,
  input  logic                     zero_i,
  output logic                     PCWrite,
  output logic                     IRWrite,
  output logic                     MemWrite,
  output logic                     RegWrite,
  output logic                     AdrSrc,
  output logic [1:0]               ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [1:0]               ResultSrc,
  output logic [1:0]               ImmSrc,
  output logic [ALUCTRL_WIDTH-1:0] ALUctrl,
  output logic                     illegal_o
);
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BEQ      = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = ALUCTRL_WIDTH'(3'b000);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = ALUCTRL_WIDTH'(3'b001);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND = ALUCTRL_WIDTH'(3'b010);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR  = ALUCTRL_WIDTH'(3'b011);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT = ALUCTRL_WIDTH'(3'b101);

  logic [3:0] state, state_nx;
  logic [ALUCTRL_WIDTH-1:0] alu_dec;
  logic pc_we, ir_we, mem_we, reg_we, ill;

  // state register; reset lands in FETCH immediately, even mid-instruction
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= FETCH;
    else state <= state_nx;

  // next-state: decode dispatches on opcode, every path ends back in FETCH
  always_comb begin
    state_nx = FETCH;
    case (state)
      FETCH:    state_nx = DECODE;
      DECODE:   state_nx = (op == OP_LW || op == OP_SW) ? MEMADR :
                           op == OP_R   ? EXECUTER :
                           op == OP_I   ? EXECUTEI :
                           op == OP_JAL ? JAL :
                           op == OP_BEQ ? BEQ : FETCH;
      MEMADR:   state_nx = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nx = MEMWB;
      EXECUTER: state_nx = ALUWB;
      EXECUTEI: state_nx = ALUWB;
      JAL:      state_nx = ALUWB;
      default:  state_nx = FETCH;
    endcase
  end

  // ALU operation for register and immediate arithmetic; sub only for R-type
  always_comb
    alu_dec = funct3 == 3'b000 ? ((op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD) :
              funct3 == 3'b010 ? ALU_SLT :
              funct3 == 3'b110 ? ALU_OR  :
              funct3 == 3'b111 ? ALU_AND : ALU_ADD;

  // immediate format is a pure function of the opcode
  always_comb
    ImmSrc = op == OP_SW  ? 2'b01 :
             op == OP_BEQ ? 2'b10 :
             op == OP_JAL ? 2'b11 : 2'b00;

  // per-state datapath controls; write enables are gathered before reset gating
  always_comb begin
    pc_we = 1'b0;
    ir_we = 1'b0;
    mem_we = 1'b0;
    reg_we = 1'b0;
    ill = 1'b0;
    AdrSrc = 1'b0;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ResultSrc = 2'b00;
    ALUctrl = ALU_ADD;
    case (state)
      FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ill = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_JAL || op == OP_BEQ);
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_we = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUctrl = alu_dec;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUctrl = alu_dec;
      end
      ALUWB: reg_we = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUctrl = ALU_SUB;
        pc_we = zero_i;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we = 1'b1;
      end
      default: ;
    endcase
  end

  // reset suppresses every architectural write and the illegal pulse
  always_comb begin
    PCWrite = pc_we & ~rst;
    IRWrite = ir_we & ~rst;
    MemWrite = mem_we & ~rst;
    RegWrite = reg_we & ~rst;
    illegal_o = ill & ~rst;
  end
endmodule
